// File: rtl/fir_decim_out_if.sv
// fir_decim_out_if: sample/stream bundle for the FIR decimating output stage.
//   Data_in, sample_en : filter result and its new-sample strobe (into the stage)
//   Data_out, out_valid, out_ready : show-ahead valid/ready output stream
//   overflow           : sticky FIFO-full drop flag
//   sat_count          : count of saturated, FIFO-written samples
// Modports: master = upstream filter plus downstream consumer, slave = the output stage.
interface fir_decim_out_if #(
  parameter int word_size_in  = 17,
  parameter int word_size_out = 8
);
  logic [word_size_in-1:0]  Data_in;
  logic                     sample_en;
  logic [word_size_out-1:0] Data_out;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overflow;
  logic [15:0]              sat_count;

  modport master (
    output Data_in, sample_en, out_ready,
    input  Data_out, out_valid, overflow, sat_count
  );

  modport slave (
    input  Data_in, sample_en, out_ready,
    output Data_out, out_valid, overflow, sat_count
  );
endinterface

// File: rtl/fir_decim_out.sv
// fir_decim_out: decimating output stage for the 8th-order FIR lowpass.
// Keeps every DECIM-th sample, rescales it by an arithmetic right shift of
// SHIFT bits with round-half-up, saturates to word_size_out bits, and buffers
// the result in a FIFO_DEPTH-entry show-ahead FIFO read over valid/ready.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fir_decim_out_if.slave (Data_in, sample_en, Data_out, out_valid,
//           out_ready, overflow, sat_count)
// Optional feature: define FIR_DECIM_SATCNT_EN to build the saturating
// sat_count counter; otherwise sat_count is tied to zero.
module fir_decim_out #(
  parameter int word_size_in  = 17,
  parameter int word_size_out = 8,
  parameter int SHIFT         = 7,
  parameter int DECIM         = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic           clock,
  input  logic           reset,
  fir_decim_out_if.slave bus
);

  localparam int RW = word_size_in + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0]        LAST_PHASE = PW'(DECIM - 1);
  localparam logic signed [RW-1:0] HALF       = RW'(2 ** (SHIFT - 1));
  localparam logic signed [RW-1:0] SAT_MAX    = RW'(2 ** (word_size_out - 1) - 1);
  localparam logic signed [RW-1:0] SAT_MIN    = ~SAT_MAX;
  localparam logic [AW:0]          FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  // Decimation phase
  logic [PW-1:0] phase;
  logic          keep;

  assign keep = bus.sample_en && (phase == LAST_PHASE);

  // Stage 1: round (one extra bit so the rounding constant cannot wrap)
  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] s1_data;
  logic                 s1_valid;

  assign rnd_sum = $signed({bus.Data_in[word_size_in-1], bus.Data_in}) + HALF;

  // Stage 2: saturate
  logic [word_size_out-1:0] sat_val;
  logic [word_size_out-1:0] s2_data;
  logic                     s2_valid;

  always_comb begin
    sat_val = s1_data[word_size_out-1:0];
    if (s1_data > SAT_MAX) begin
      sat_val = SAT_MAX[word_size_out-1:0];
    end else if (s1_data < SAT_MIN) begin
      sat_val = SAT_MIN[word_size_out-1:0];
    end
  end

  // Output FIFO
  logic [word_size_out-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              count;
  logic [word_size_out-1:0] last_q;
  logic                     overflow_q;
  logic                     not_empty;
  logic                     full;
  logic                     pop;
  logic                     wr_en;

  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = not_empty && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en     = s2_valid && (!full || pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.sample_en) begin
        phase <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
      end

      s1_valid <= keep;
      if (keep) begin
        s1_data <= rnd_sum >>> SHIFT;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_val;
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      if (wr_en && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !wr_en) begin
        count <= count - (AW + 1)'(1);
      end

      if (s2_valid && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // Once empty, the last popped word is held rather than a stale slot.
  assign bus.Data_out  = not_empty ? mem[rd_ptr] : last_q;
  assign bus.out_valid = not_empty;
  assign bus.overflow  = overflow_q;

`ifdef FIR_DECIM_SATCNT_EN
  logic        sat_hit;
  logic        s2_sat;
  logic [15:0] sat_cnt;

  assign sat_hit = (s1_data > SAT_MAX) || (s1_data < SAT_MIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_sat  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (s1_valid) begin
        s2_sat <= sat_hit;
      end
      if (wr_en && s2_sat && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

  assign bus.sat_count = sat_cnt;
`else
  assign bus.sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: drives three fir_decim_out instances (DECIM = 4, 1, 2)
// with shared stimulus and compares every output, every cycle, against a
// sample-count / queue reference model, plus directed scenario checks.
module tb_fir_decim_out;
  localparam int WI         = 17;
  localparam int WO         = 8;
  localparam int SHIFT      = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int NDUT       = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [WI-1:0] din = '0;
  logic sen = 1'b0;
  logic rdy = 1'b0;

  always #5 clock = ~clock;

  fir_decim_out_if #(.word_size_in(WI), .word_size_out(WO)) if0 ();
  fir_decim_out_if #(.word_size_in(WI), .word_size_out(WO)) if1 ();
  fir_decim_out_if #(.word_size_in(WI), .word_size_out(WO)) if2 ();

  assign if0.Data_in = din;  assign if0.sample_en = sen;  assign if0.out_ready = rdy;
  assign if1.Data_in = din;  assign if1.sample_en = sen;  assign if1.out_ready = rdy;
  assign if2.Data_in = din;  assign if2.sample_en = sen;  assign if2.out_ready = rdy;

  fir_decim_out #(.word_size_in(WI), .word_size_out(WO), .SHIFT(SHIFT),
                  .DECIM(4), .FIFO_DEPTH(FIFO_DEPTH))
    u_dut0 (.clock(clock), .reset(reset), .bus(if0));
  fir_decim_out #(.word_size_in(WI), .word_size_out(WO), .SHIFT(SHIFT),
                  .DECIM(1), .FIFO_DEPTH(FIFO_DEPTH))
    u_dut1 (.clock(clock), .reset(reset), .bus(if1));
  fir_decim_out #(.word_size_in(WI), .word_size_out(WO), .SHIFT(SHIFT),
                  .DECIM(2), .FIFO_DEPTH(FIFO_DEPTH))
    u_dut2 (.clock(clock), .reset(reset), .bus(if2));

  logic [WO-1:0] obs_d [NDUT];
  logic          obs_v [NDUT];
  logic          obs_o [NDUT];
  logic [15:0]   obs_s [NDUT];

  assign obs_d[0] = if0.Data_out; assign obs_v[0] = if0.out_valid;
  assign obs_o[0] = if0.overflow; assign obs_s[0] = if0.sat_count;
  assign obs_d[1] = if1.Data_out; assign obs_v[1] = if1.out_valid;
  assign obs_o[1] = if1.overflow; assign obs_s[1] = if1.sat_count;
  assign obs_d[2] = if2.Data_out; assign obs_v[2] = if2.out_valid;
  assign obs_o[2] = if2.overflow; assign obs_s[2] = if2.sat_count;

  // Reference model state
  typedef struct {
    int t;
    int v;
    bit s;
  } pend_t;

  pend_t pend    [NDUT][$];
  int    fifo_m  [NDUT][$];
  int    seen_m  [NDUT];
  int    last_m  [NDUT];
  bit    ovf_m   [NDUT];
  int    satc_m  [NDUT];
  int    cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dec_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  // Round-half-up division by 2^SHIFT, then clamp to the output range.
  function automatic void rescale(input logic [WI-1:0] d, output int q, output bit s);
    int x;
    int r;
    int div;
    int maxv;
    x    = int'(d);
    if (d[WI-1]) x = x - (1 << WI);
    div  = 1 << SHIFT;
    maxv = (1 << (WO - 1)) - 1;
    r    = x + div / 2;
    if (r >= 0) q = r / div;
    else        q = -((-r + div - 1) / div);
    s = 1'b0;
    if (q > maxv) begin
      q = maxv;
      s = 1'b1;
    end else if (q < -maxv - 1) begin
      q = -maxv - 1;
      s = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NDUT; k++) begin
      pend[k].delete();
      fifo_m[k].delete();
      seen_m[k] = 0;
      last_m[k] = 0;
      ovf_m[k]  = 1'b0;
      satc_m[k] = 0;
    end
  endfunction

  function automatic void model_edge(input int k);
    pend_t p;
    int    q;
    bit    s;
    if (fifo_m[k].size() != 0 && rdy) last_m[k] = fifo_m[k].pop_front();
    if (pend[k].size() != 0 && pend[k][0].t == cyc) begin
      p = pend[k].pop_front();
      if (fifo_m[k].size() < FIFO_DEPTH) begin
        fifo_m[k].push_back(p.v);
        if (p.s && satc_m[k] < 65535) satc_m[k]++;
      end else begin
        ovf_m[k] = 1'b1;
      end
    end
    if (sen) begin
      seen_m[k]++;
      if (seen_m[k] % dec_of(k) == 0) begin
        rescale(din, q, s);
        p.t = cyc + 2;
        p.v = q;
        p.s = s;
        pend[k].push_back(p);
      end
    end
  endfunction

  task automatic compare_all();
    int exp_d;
    int exp_s;
    for (int k = 0; k < NDUT; k++) begin
      exp_d = (fifo_m[k].size() != 0) ? fifo_m[k][0] : last_m[k];
`ifdef FIR_DECIM_SATCNT_EN
      exp_s = satc_m[k];
`else
      exp_s = 0;
`endif
      check($sformatf("dut%0d.out_valid@%0d", k, cyc), int'(obs_v[k]),
            (fifo_m[k].size() != 0) ? 1 : 0);
      check($sformatf("dut%0d.Data_out@%0d", k, cyc), int'(obs_d[k]), exp_d & 8'hFF);
      check($sformatf("dut%0d.overflow@%0d", k, cyc), int'(obs_o[k]), int'(ovf_m[k]));
      check($sformatf("dut%0d.sat_count@%0d", k, cyc), int'(obs_s[k]), exp_s);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (reset) begin
      for (int k = 0; k < NDUT; k++) model_edge(k);
    end else begin
      model_clear();
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    compare_all();
    tick();
    tick();
    reset = 1'b1;
  endtask

  int got [$];
  int exp2 [5];
  int n;
  int cnt [NDUT];

  initial begin
    exp2 = '{8'h00, 8'h01, 8'h01, 8'h7F, 8'h80};
    model_clear();
    #2;
    compare_all();
    check("rst_valid", int'(obs_v[0]), 0);
    check("rst_data", int'(obs_d[0]), 0);
    do_reset();

    // DECIM=4 latency and rounding
    rdy = 1'b1;
    sen = 1'b1;
    din = 17'h00040; tick();
    din = 17'h00040; tick();
    din = 17'h00040; tick();
    din = 17'h000C0; tick();
    sen = 1'b0;
    din = '0;
    tick();
    check("t1_valid_n1", int'(obs_v[0]), 0);
    tick();
    check("t1_valid_n2", int'(obs_v[0]), 1);
    check("t1_data", int'(obs_d[0]), 8'h02);
    repeat (4) tick();

    // DECIM=1 rounding and saturation
    do_reset();
    rdy = 1'b1;
    got.delete();
    sen = 1'b1;
    for (int i = 0; i < 11; i++) begin
      case (i)
        0: din = 17'h0003F;
        1: din = 17'h00040;
        2: din = 17'h00080;
        3: din = 17'h0FFFF;
        4: din = 17'h10000;
        default: begin
          sen = 1'b0;
          din = '0;
        end
      endcase
      tick();
      if (obs_v[1]) got.push_back(int'(obs_d[1]));
    end
    check("t2_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check($sformatf("t2_out%0d", i), got[i], exp2[i]);
    end
`ifdef FIR_DECIM_SATCNT_EN
    check("t2_satcnt", int'(obs_s[1]), 2);
`else
    check("t2_satcnt", int'(obs_s[1]), 0);
`endif

    // Stalled consumer: fill, overflow, then drain in order
    do_reset();
    rdy = 1'b0;
    sen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = WI'((i + 1) * 'h80);
      tick();
    end
    sen = 1'b0;
    repeat (3) tick();
    check("t3_ovf", int'(obs_o[1]), 1);
    check("t3_head", int'(obs_d[1]), 1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain%0d", i), int'(obs_d[1]), i + 1);
      tick();
    end
    check("t3_empty", int'(obs_v[1]), 0);
    check("t3_hold", int'(obs_d[1]), 4);

    // Full FIFO with simultaneous pop and write
    do_reset();
    rdy = 1'b0;
    sen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = WI'((i + 1) * 'h80);
      tick();
    end
    sen = 1'b0;
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("t4_ovf", int'(obs_o[1]), 0);
    check("t4_head", int'(obs_d[1]), 2);
    rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (obs_v[1]) begin
        check($sformatf("t4_order%0d", n), int'(obs_d[1]), n + 2);
        n++;
      end
      tick();
    end
    check("t4_count", n, 4);

    // Reset mid-stream with 3 entries buffered
    do_reset();
    rdy = 1'b0;
    sen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = WI'((i + 1) * 'h80);
      tick();
    end
    sen = 1'b0;
    repeat (2) tick();
    check("t5_pre_valid", int'(obs_v[1]), 1);
    reset = 1'b0;
    model_clear();
    #1;
    check("t5_rst_valid", int'(obs_v[1]), 0);
    check("t5_rst_ovf", int'(obs_o[1]), 0);
    compare_all();
    tick();
    reset = 1'b1;
    sen = 1'b1;
    din = 17'h00200; tick();
    din = 17'h00180; tick();
    din = 17'h00100; tick();
    din = 17'h00280; tick();
    sen = 1'b0;
    repeat (2) tick();
    check("t5_first_valid", int'(obs_v[0]), 1);
    check("t5_first_data", int'(obs_d[0]), 5);

    // Gapped sample_en: phase moves only on enabled cycles
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sen = (i % 2 == 0);
      din = WI'((i + 1) * 'h80);
      tick();
    end
    sen = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    for (int k = 0; k < NDUT; k++) cnt[k] = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NDUT; k++) if (obs_v[k]) cnt[k]++;
      tick();
    end
    check("t6_dec4", cnt[0], 1);
    check("t6_dec1", cnt[1], 4);
    check("t6_dec2", cnt[2], 2);

    // Randomized traffic with stall windows and occasional reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      sen = ($urandom_range(0, 3) != 0);
      if ((c / 40) % 3 == 1) rdy = 1'b0;
      else                   rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       din = WI'($urandom);
        1:       din = WI'(17'h0FF00 + $urandom_range(0, 255));
        2:       din = WI'(17'h10000 + $urandom_range(0, 255));
        default: din = WI'($urandom_range(0, 511));
      endcase
      tick();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
